// File: rtl/jtcps2_obj_pkg.sv
// Shared types and constants for the CPS2 object-table copy engine.
package jtcps2_obj_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WR, SWAP} obj_state_t;

    localparam int          END_MARK_BIT = 15;
    localparam logic [15:0] END_FILL     = 16'hFFFF;

    function automatic int calc_ew(input int entries, input int words);
        return $clog2(entries * words);
    endfunction

endpackage

// File: rtl/jtcps2_oframe_trig.sv
// Once-per-frame trigger from the rising edge of vdump==TRIG_LINE, plus the sticky overrun flag.
module jtcps2_oframe_trig
    import jtcps2_obj_pkg::*;
#(
    parameter logic [8:0] TRIG_LINE = 9'd240
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pxl_cen,
    input  logic [8:0] i_vdump,
    input  logic       i_busy,
    output logic       o_trig,
    output logic       o_overrun
);

    logic [8:0] r_vdump_last;
    logic       r_overrun;

    assign o_trig    = i_pxl_cen && (i_vdump == TRIG_LINE) && (r_vdump_last != TRIG_LINE);
    assign o_overrun = r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vdump_last <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (i_pxl_cen) r_vdump_last <= i_vdump;
            if (o_trig && i_busy) r_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/jtcps2_oframe_dma.sv
// Copies ORAM into the inactive half of a double-buffered frame table once per frame, then swaps.
// Optional JTCPS2_OBJ_EARLYEND_EN: a y word with bit 15 set ends the list early.
module jtcps2_oframe_dma
    import jtcps2_obj_pkg::*;
#(
    parameter int         ENTRIES   = 1024,
    parameter int         WORDS     = 4,
    parameter logic [8:0] TRIG_LINE = 9'd240,
    localparam int        EW        = calc_ew(ENTRIES, WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pxl_cen,
    input  logic [8:0]    i_vdump,
    input  logic          i_obank,
    output logic [EW:0]   o_oram_addr,
    output logic          o_oram_cs,
    input  logic          i_oram_ok,
    input  logic [15:0]   i_oram_data,
    output logic          o_oframe_we,
    output logic [EW-1:0] o_oframe_addr,
    output logic [15:0]   o_oframe_data,
    output logic          o_obank_frame,
    output logic          o_busy,
    output logic          o_overrun
);

    localparam logic [EW-1:0] LAST_IDX = EW'(ENTRIES * WORDS - 1);

    obj_state_t    r_state, w_state_nx;
    logic [EW-1:0] r_idx, w_idx_nx;
    logic          r_obank_lat, w_obank_lat_nx;
    logic [15:0]   r_data, w_data_nx;
    logic          r_busy, w_busy_nx;
    logic          r_obank_frame, w_obank_frame_nx;
    logic          r_settled, w_settled_nx;
    logic          w_trig;

`ifdef JTCPS2_OBJ_EARLYEND_EN
    localparam int WB = $clog2(WORDS);
    logic r_fill, w_fill_nx;
    logic w_is_y, w_last_entry;
    assign w_is_y       = (r_idx & EW'(WORDS - 1)) == EW'(1);
    assign w_last_entry = (r_idx >> WB) == EW'(ENTRIES - 1);
`endif

    jtcps2_oframe_trig #(.TRIG_LINE(TRIG_LINE)) u_trig (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pxl_cen (i_pxl_cen),
        .i_vdump   (i_vdump),
        .i_busy    (r_busy),
        .o_trig    (w_trig),
        .o_overrun (o_overrun)
    );

    assign o_oram_addr   = {r_obank_lat, r_idx};
    assign o_oram_cs     = (r_state == REQ) || (r_state == WAIT);
    assign o_oframe_we   = (r_state == WR);
    assign o_oframe_addr = r_idx;
    assign o_oframe_data = r_data;
    assign o_obank_frame = r_obank_frame;
    assign o_busy        = r_busy;

    always_comb begin
        w_state_nx       = r_state;
        w_idx_nx         = r_idx;
        w_obank_lat_nx   = r_obank_lat;
        w_data_nx        = r_data;
        w_busy_nx        = r_busy;
        w_obank_frame_nx = r_obank_frame;
        w_settled_nx     = r_settled;
`ifdef JTCPS2_OBJ_EARLYEND_EN
        w_fill_nx        = r_fill;
`endif
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_obank_lat_nx = i_obank;
                    w_idx_nx       = '0;
                    w_busy_nx      = 1'b1;
                    w_state_nx     = REQ;
                end
            end
            REQ: begin
                w_settled_nx = 1'b0;
                w_state_nx   = WAIT;
            end
            WAIT: begin
                // first WAIT cycle lets SDRAM settle; ok is only honoured afterwards
                w_settled_nx = 1'b1;
                if (r_settled && i_oram_ok) begin
                    w_data_nx  = i_oram_data;
                    w_state_nx = WR;
                end
            end
            WR: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nx = SWAP;
                end else begin
                    w_idx_nx   = r_idx + EW'(1);
                    w_state_nx = REQ;
                end
`ifdef JTCPS2_OBJ_EARLYEND_EN
                if (r_fill) begin
                    w_idx_nx   = r_idx;
                    w_state_nx = SWAP;
                end else if (w_is_y && r_data[END_MARK_BIT]) begin
                    if (w_last_entry) begin
                        w_idx_nx   = r_idx;
                        w_state_nx = SWAP;
                    end else begin
                        // terminate the scan list by poisoning the next entry's y word
                        w_idx_nx   = r_idx + EW'(WORDS);
                        w_data_nx  = END_FILL;
                        w_fill_nx  = 1'b1;
                        w_state_nx = WR;
                    end
                end
`endif
            end
            SWAP: begin
                w_obank_frame_nx = ~r_obank_frame;
                w_busy_nx        = 1'b0;
                w_state_nx       = IDLE;
`ifdef JTCPS2_OBJ_EARLYEND_EN
                w_fill_nx        = 1'b0;
`endif
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_obank_lat   <= 1'b0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_obank_frame <= 1'b0;
            r_settled     <= 1'b0;
`ifdef JTCPS2_OBJ_EARLYEND_EN
            r_fill        <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_obank_lat   <= w_obank_lat_nx;
            r_data        <= w_data_nx;
            r_busy        <= w_busy_nx;
            r_obank_frame <= w_obank_frame_nx;
            r_settled     <= w_settled_nx;
`ifdef JTCPS2_OBJ_EARLYEND_EN
            r_fill        <= w_fill_nx;
`endif
        end
    end

endmodule

// File: tb/tb_jtcps2_oframe_dma.sv
// Directed bench for jtcps2_oframe_dma with ENTRIES=4, WORDS=4 and a behavioural ORAM source.
module tb_jtcps2_oframe_dma;

    localparam int ENTRIES = 4;
    localparam int WORDS   = 4;
    localparam int NW      = ENTRIES * WORDS;
    localparam int EW      = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pxl_cen;
    logic [8:0]    vdump;
    logic          obank;
    logic [EW:0]   oram_addr;
    logic          oram_cs;
    logic          oram_ok;
    logic [15:0]   oram_data;
    logic          oframe_we;
    logic [EW-1:0] oframe_addr;
    logic [15:0]   oframe_data;
    logic          obank_frame;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    jtcps2_oframe_dma #(.ENTRIES(ENTRIES), .WORDS(WORDS), .TRIG_LINE(9'd240)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pxl_cen     (pxl_cen),
        .i_vdump       (vdump),
        .i_obank       (obank),
        .o_oram_addr   (oram_addr),
        .o_oram_cs     (oram_cs),
        .i_oram_ok     (oram_ok),
        .i_oram_data   (oram_data),
        .o_oframe_we   (oframe_we),
        .o_oframe_addr (oframe_addr),
        .o_oframe_data (oframe_data),
        .o_obank_frame (obank_frame),
        .o_busy        (busy),
        .o_overrun     (overrun)
    );

    logic [15:0] src [0:2*NW-1];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_frame;

    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          n_req, n_unstable, n_msb_bad, n_run_bad, n_toggle;

    // Runs one frame: trigger, then serve ORAM reads cycle by cycle while recording what the DUT does.
    task automatic run_frame(input bit ok_tied, input bit bank, input bit flip, input bit retrig,
                             input int abort_at, output bit timeout, output bit aborted);
        int k, lat, run_exp;
        logic [EW:0] req_addr;
        bit prev_cs, prev_frame, seen_busy;
        wr_addr.delete(); wr_data.delete();
        n_req = 0; n_unstable = 0; n_msb_bad = 0; n_run_bad = 0; n_toggle = 0;
        timeout = 1'b1; aborted = 1'b0;
        k = 0; lat = 0; run_exp = 3; prev_cs = 1'b0; seen_busy = 1'b0; req_addr = '0;
        obank = bank;
        vdump = 9'd239;
        @(negedge clk);
        vdump = 9'd240;
        @(negedge clk);
        vdump = 9'd241;
        prev_frame = obank_frame;
        for (int c = 0; c < 2000; c++) begin
            if (busy) seen_busy = 1'b1;
            if (obank_frame !== prev_frame) n_toggle++;
            prev_frame = obank_frame;
            if (oframe_we) begin
                wr_addr.push_back(int'(oframe_addr));
                wr_data.push_back(oframe_data);
                if (k + 1 != run_exp) n_run_bad++;
                if (abort_at == int'(oframe_addr)) begin
                    aborted = 1'b1;
                    timeout = 1'b0;
                    return;
                end
            end
            if (seen_busy && !busy) begin
                timeout = 1'b0;
                return;
            end
            if (oram_cs) begin
                if (!prev_cs) begin
                    k = 0;
                    n_req++;
                    req_addr = oram_addr;
                    lat = ok_tied ? 0 : int'($urandom_range(7, 0));
                    run_exp = 3 + lat;
                end else begin
                    k++;
                end
                if (oram_addr !== req_addr) n_unstable++;
                if (oram_addr[EW] !== bank) n_msb_bad++;
                // ok is also raised in REQ and the first WAIT cycle with bogus data as a decoy
                oram_ok   = ok_tied ? 1'b1 : ((k <= 1) || (k >= 2 + lat));
                oram_data = (ok_tied || k >= 2 + lat) ? src[oram_addr] : 16'hBAD0;
            end else begin
                oram_ok   = ok_tied ? 1'b1 : 1'($urandom_range(1, 0));
                oram_data = ok_tied ? src[oram_addr] : 16'hBAD0;
            end
            prev_cs = oram_cs;
            vdump = (retrig && c == 20) ? 9'd239 : (retrig && c == 21) ? 9'd240 : 9'd241;
            if (flip && c == 30) obank = ~bank;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pxl_cen = 1'b1; vdump = 9'd0; obank = 1'b0; oram_ok = 1'b0; oram_data = 16'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, oram_cs, oframe_we, obank_frame, overrun} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b exp 00000", {busy, oram_cs, oframe_we, obank_frame, overrun});
        end
        n_cmp++;
        if (oram_addr !== '0) begin n_err++; $display("FAIL reset_oram_addr: got %0h exp 0", oram_addr); end
        n_cmp++;
        if ({oframe_addr, oframe_data} !== '0) begin
            n_err++; $display("FAIL reset_oframe: got %0h/%0h exp 0/0", oframe_addr, oframe_data);
        end
        rst = 1'b0;
        exp_frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to, ab;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, to, ab);
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %0d exp 0", to); end
        n_cmp++;
        if (wr_addr.size() != NW) begin n_err++; $display("FAIL basic_count: got %0d exp %0d", wr_addr.size(), NW); end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== src[i]) begin
                n_err++; $display("FAIL basic_word%0d: got %0d/%0h exp %0d/%0h", i, wr_addr[i], wr_data[i], i, src[i]);
            end
        end
        n_cmp++;
        if (n_run_bad != 0) begin n_err++; $display("FAIL basic_latency: got %0d bad runs exp 0", n_run_bad); end
        n_cmp++;
        if (obank_frame !== exp_frame || n_toggle != 1) begin
            n_err++; $display("FAIL basic_swap: got %b/%0d toggles exp %b/1", obank_frame, n_toggle, exp_frame);
        end
        n_cmp++;
        if ({busy, overrun} !== 2'b00) begin n_err++; $display("FAIL basic_idle: got %b exp 00", {busy, overrun}); end
    endtask

    task automatic test_latency();
        bit to, ab;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, to, ab);
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL lat_timeout: got %0d exp 0", to); end
        n_cmp++;
        if (n_unstable != 0) begin n_err++; $display("FAIL lat_addr_stable: got %0d exp 0", n_unstable); end
        n_cmp++;
        if (n_run_bad != 0) begin n_err++; $display("FAIL lat_accept_cycle: got %0d exp 0", n_run_bad); end
        n_cmp++;
        if (wr_addr.size() != NW) begin n_err++; $display("FAIL lat_count: got %0d exp %0d", wr_addr.size(), NW); end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== src[i]) begin
                n_err++; $display("FAIL lat_word%0d: got %0d/%0h exp %0d/%0h", i, wr_addr[i], wr_data[i], i, src[i]);
            end
        end
        n_cmp++;
        if (obank_frame !== exp_frame) begin n_err++; $display("FAIL lat_frame: got %b exp %b", obank_frame, exp_frame); end
    endtask

    task automatic test_overrun();
        bit to, ab;
        run_frame(1'b1, 1'b0, 1'b0, 1'b1, -1, to, ab);
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL ovr_timeout: got %0d exp 0", to); end
        n_cmp++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
        n_cmp++;
        if (wr_addr.size() != NW || n_req != NW) begin
            n_err++; $display("FAIL ovr_count: got %0d writes %0d reqs exp %0d", wr_addr.size(), n_req, NW);
        end
        n_cmp++;
        if (n_toggle != 1 || obank_frame !== exp_frame) begin
            n_err++; $display("FAIL ovr_swap: got %0d toggles frame %b exp 1/%b", n_toggle, obank_frame, exp_frame);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            n_err++; $display("FAIL ovr_after: got busy %b ovr %b exp 0/1", busy, overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit to, ab;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 5, to, ab);
        n_cmp++;
        if (ab !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_reach5: got %b/%b exp 1/1", ab, busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, oram_cs, obank_frame, overrun, oframe_we} !== 5'b0) begin
            n_err++; $display("FAIL rmid_cleared: got %b exp 00000", {busy, oram_cs, obank_frame, overrun, oframe_we});
        end
        rst = 1'b0;
        exp_frame = 1'b0;
        @(negedge clk);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, to, ab);
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0 || wr_addr.size() != NW) begin
            n_err++; $display("FAIL rmid_restart: got timeout %0d writes %0d exp 0/%0d", to, wr_addr.size(), NW);
        end
        n_cmp++;
        if (wr_addr.size() == 0 || wr_addr[0] != 0) begin
            n_err++; $display("FAIL rmid_first_idx: got %0d exp 0", (wr_addr.size() == 0) ? -1 : wr_addr[0]);
        end
        n_cmp++;
        if (obank_frame !== exp_frame) begin n_err++; $display("FAIL rmid_frame: got %b exp %b", obank_frame, exp_frame); end
    endtask

    task automatic test_obank();
        bit to, ab;
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, -1, to, ab);
        obank = 1'b0;
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL obank_timeout: got %0d exp 0", to); end
        n_cmp++;
        if (n_msb_bad != 0 || n_req != NW) begin
            n_err++; $display("FAIL obank_msb: got %0d bad of %0d reqs exp 0 of %0d", n_msb_bad, n_req, NW);
        end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== src[NW + i]) begin
                n_err++; $display("FAIL obank_word%0d: got %0d/%0h exp %0d/%0h", i, wr_addr[i], wr_data[i], i, src[NW + i]);
            end
        end
        n_cmp++;
        if (obank_frame !== exp_frame) begin n_err++; $display("FAIL obank_frame: got %b exp %b", obank_frame, exp_frame); end
    endtask

    task automatic test_earlyend();
        bit to, ab;
        int exp_a[$];
        logic [15:0] exp_d[$];
        int exp_req;
        src[9] = 16'h8000;
`ifdef JTCPS2_OBJ_EARLYEND_EN
        for (int i = 0; i <= 9; i++) begin exp_a.push_back(i); exp_d.push_back(src[i]); end
        exp_a.push_back(13); exp_d.push_back(16'hFFFF);
        exp_req = 10;
`else
        for (int i = 0; i < NW; i++) begin exp_a.push_back(i); exp_d.push_back(src[i]); end
        exp_req = NW;
`endif
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, to, ab);
        exp_frame = ~exp_frame;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL early_timeout: got %0d exp 0", to); end
        n_cmp++;
        if (wr_addr.size() != exp_a.size() || n_req != exp_req) begin
            n_err++; $display("FAIL early_count: got %0d writes %0d reqs exp %0d/%0d", wr_addr.size(), n_req, exp_a.size(), exp_req);
        end
        for (int i = 0; i < exp_a.size() && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) begin
                n_err++; $display("FAIL early_word%0d: got %0d/%0h exp %0d/%0h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
            end
        end
        n_cmp++;
        if (n_toggle != 1 || obank_frame !== exp_frame) begin
            n_err++; $display("FAIL early_swap: got %0d toggles frame %b exp 1/%b", n_toggle, obank_frame, exp_frame);
        end
    endtask

    initial begin
        for (int i = 0; i < 2 * NW; i++) src[i] = 16'(16'h1000 + i * 16'h0101);
        test_reset();
        test_basic();
        test_latency();
        test_overrun();
        test_reset_mid();
        test_obank();
        test_earlyend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
